// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared constants and state encoding for the Wishbone
//                request master (data/select widths, FSM state codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Bus data width and byte-lane select width (8-bit granularity)
    localparam int c_DW = 32;
    localparam int c_SW = 4;

    // FSM state type and codes
    typedef logic [0:0] wb_state_t;
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : wb_watchdog
//  Description : Loadable down-counter. Loaded when a strobe is issued,
//                decremented on every running cycle, and flags expiry when a
//                running cycle finds the count already at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [CNTW-1:0] i_load_val,
    input  logic            i_run,
    output logic            o_expire
);

    logic [CNTW-1:0] r_cnt;

    // Count register: load takes priority, otherwise count down while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Expiry is only meaningful on a running (un-acknowledged) cycle
    assign o_expire = i_run && (r_cnt == '0);

endmodule : wb_watchdog
`default_nettype wire

// File: rtl/wb_req_master.sv
`default_nettype none
// ============================================================================
//  Module      : wb_req_master
//  Description : Single-outstanding Wishbone B.4 classic-cycle master.
//                Accepts valid/ready requests, drives the bus, and returns
//                a one-cycle response pulse (read data or write completion).
//                A watchdog aborts cycles the slave never acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_req_master
    import wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 8
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    // request side
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_adr,
    input  logic [c_SW-1:0] req_sel,
    input  logic [c_DW-1:0] req_wdat,
    // response side
    output logic            rsp_valid,
    output logic [c_DW-1:0] rsp_rdat,
    output logic            rsp_err,
    // Wishbone master side
    output logic            CYC_O,
    output logic            STB_O,
    output logic            WE_O,
    output logic [AW-1:0]   ADR_O,
    output logic [c_SW-1:0] SEL_O,
    output logic [c_DW-1:0] DAT_O,
    input  logic [c_DW-1:0] DAT_I,
    input  logic            ACK_I
);

    // The watchdog counter must be able to hold TIMEOUT-1
    generate
        if ((TIMEOUT < 0) || ((TIMEOUT >> CNTW) != 0)) begin : g_bad_timeout
            $error("wb_req_master: TIMEOUT must be in [0, 2**CNTW)");
        end
    endgenerate

    wb_state_t       r_state;
    logic            r_cyc;
    logic            r_stb;
    logic            r_we;
    logic [AW-1:0]   r_adr;
    logic [c_SW-1:0] r_sel;
    logic [c_DW-1:0] r_dat;
    logic            r_rsp_valid;
    logic [c_DW-1:0] r_rsp_rdat;
    logic            r_rsp_err;

    logic            w_active;
    logic            w_ack;
    logic            w_accept;
    logic            w_expire;

    // ACK_I only counts while our strobe is up, so a slave holding ACK
    // permanently high cannot create responses from an idle bus.
    assign w_active  = (r_state == c_ST_ACTIVE);
    assign w_ack     = ACK_I && r_stb;
    assign req_ready = (r_state == c_ST_IDLE) || w_ack;
    assign w_accept  = req_valid && req_ready;

    generate
        if (TIMEOUT > 0) begin : g_wd
            wb_watchdog #(
                .CNTW (CNTW)
            ) u_wd (
                .clk        (CLK_I),
                .rst        (RST_I),
                .i_load     (w_accept),
                .i_load_val (CNTW'(TIMEOUT - 1)),
                .i_run      (w_active && !ACK_I),
                .o_expire   (w_expire)
            );
        end else begin : g_no_wd
            assign w_expire = 1'b0;
        end
    endgenerate

    // Bus-side FSM: load on accept (also back-to-back), release on ACK or abort
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= c_ST_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
        end else if (w_accept) begin
            r_state <= c_ST_ACTIVE;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= req_we;
            r_adr   <= req_adr;
            r_sel   <= req_sel;
            r_dat   <= req_we ? req_wdat : '0;
        end else if (w_active && (w_ack || w_expire)) begin
            r_state <= c_ST_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
        end
    end

    // Response pulse: data only on acknowledged reads, error only on abort
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdat  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_ack || w_expire;
            r_rsp_err   <= w_expire;
            r_rsp_rdat  <= (w_ack && !r_we) ? DAT_I : '0;
        end
    end

    assign CYC_O     = r_cyc;
    assign STB_O     = r_stb;
    assign WE_O      = r_we;
    assign ADR_O     = r_adr;
    assign SEL_O     = r_sel;
    assign DAT_O     = r_dat;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdat  = r_rsp_rdat;
    assign rsp_err   = r_rsp_err;

endmodule : wb_req_master
`default_nettype wire

// File: tb/tb_wb_req_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_req_master
//  Description : Self-checking bench for wb_req_master with a behavioural
//                single-register Wishbone slave (programmable latency, ACK
//                held high or tied low).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_req_master;

    localparam int AW      = 32;
    localparam int TIMEOUT = 4;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [3:0]  req_sel;
    logic [31:0] req_wdat;
    logic        rsp_valid;
    logic [31:0] rsp_rdat;
    logic        rsp_err;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [31:0] ADR_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    wb_req_master #(
        .AW      (AW),
        .TIMEOUT (TIMEOUT),
        .CNTW    (8)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_sel   (req_sel),
        .req_wdat  (req_wdat),
        .rsp_valid (rsp_valid),
        .rsp_rdat  (rsp_rdat),
        .rsp_err   (rsp_err),
        .CYC_O     (CYC_O),
        .STB_O     (STB_O),
        .WE_O      (WE_O),
        .ADR_O     (ADR_O),
        .SEL_O     (SEL_O),
        .DAT_O     (DAT_O),
        .DAT_I     (DAT_I),
        .ACK_I     (ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    // ---------------- behavioural slave ----------------
    // ack_mode: 0 = ACK after slv_lat wait cycles, 1 = held high, 2 = tied low
    logic [1:0]  ack_mode = 2'd0;
    int          slv_lat  = 0;
    int          wcnt     = 0;
    logic [31:0] mem      = 32'hdeadbabe;

    always_ff @(posedge CLK_I) begin
        if (!STB_O || ACK_I) wcnt <= 0;
        else                 wcnt <= wcnt + 1;
    end

    always_comb begin
        ACK_I = 1'b0;
        case (ack_mode)
            2'd1:    ACK_I = 1'b1;
            2'd2:    ACK_I = 1'b0;
            default: ACK_I = STB_O && (wcnt == slv_lat);
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (CYC_O && STB_O && ACK_I && WE_O) begin
            for (int b = 0; b < 4; b++) begin
                if (SEL_O[b]) mem[8*b +: 8] <= DAT_O[8*b +: 8];
            end
        end
    end

    assign DAT_I = mem;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          lat;
        logic [31:0] exp_rdat;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    // One request through the valid/ready port; checks bus, stability,
    // accept-to-response latency, response contents and pulse width.
    task automatic do_txn(input vec_t v, input string name);
        int n;
        bit got;
        bit stable;
        slv_lat = v.lat;
        @(negedge CLK_I);
        req_valid = 1'b1;
        req_we    = v.we;
        req_adr   = v.adr;
        req_sel   = v.sel;
        req_wdat  = v.wdat;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge CLK_I);
            n++;
        end
        check({name, " ready"}, 128'(req_ready), 128'd1);
        @(posedge CLK_I);
        #1;
        req_valid = 1'b0;
        check({name, " bus"}, {CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O},
              {1'b1, 1'b1, v.we, v.sel, v.adr, (v.we ? v.wdat : 32'h0)});
        stable = 1'b1;
        got    = 1'b0;
        n      = 0;
        while (!got && n < 40) begin
            @(posedge CLK_I);
            #1;
            n++;
            if (rsp_valid) got = 1'b1;
            else if (!(CYC_O && STB_O && ADR_O == v.adr && SEL_O == v.sel && WE_O == v.we))
                stable = 1'b0;
        end
        check({name, " latency"}, 128'(n), 128'(v.exp_lat));
        check({name, " stable"}, 128'(stable), 128'd1);
        check({name, " rdat"}, 128'(rsp_rdat), 128'(v.exp_rdat));
        check({name, " err"}, 128'(rsp_err), 128'(v.exp_err));
        @(posedge CLK_I);
        #1;
        check({name, " pulse"}, {rsp_valid, rsp_err, rsp_rdat}, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cnt;
        int pulses;
        vec_t v;

        //          we    adr          sel      wdat          lat rdat          err  lat
        vecs[0] = '{1'b0, 32'h0000_0000, 4'hf, 32'h0,         0, 32'hdeadbabe, 1'b0, 1};
        vecs[1] = '{1'b1, 32'h0000_0004, 4'h3, 32'h12345678,  0, 32'h0,        1'b0, 1};
        vecs[2] = '{1'b0, 32'h0000_0008, 4'hf, 32'h0,         3, 32'hdead5678, 1'b0, 4};
        vecs[3] = '{1'b1, 32'h0000_000c, 4'hc, 32'hAABBCCDD,  1, 32'h0,        1'b0, 2};
        vecs[4] = '{1'b0, 32'hffff_fffc, 4'hf, 32'h0,         2, 32'haabb5678, 1'b0, 3};
        vecs[5] = '{1'b0, 32'h0000_0010, 4'hf, 32'h0,         4, 32'h0,        1'b1, 4};
        vecs[6] = '{1'b1, 32'h0000_0014, 4'hf, 32'h0,         4, 32'h0,        1'b1, 4};
        vecs[7] = '{1'b0, 32'h0000_0018, 4'h1, 32'h0,         0, 32'haabb5678, 1'b0, 1};

        RST_I     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = '0;
        req_sel   = '0;
        req_wdat  = '0;

        // reset state
        repeat (3) @(negedge CLK_I);
        check("reset bus", {CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O}, 128'd0);
        check("reset rsp", {rsp_valid, rsp_err, rsp_rdat}, 128'd0);
        check("reset ready", 128'(req_ready), 128'd1);
        RST_I = 1'b0;

        // table-driven transactions
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // back-to-back with ACK held high: 4 writes then a read
        ack_mode = 2'd1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge CLK_I);
            if (k >= 1) begin
                check($sformatf("b2b k%0d cyc/valid/err", k), {CYC_O, rsp_valid, rsp_err},
                      {(k <= 5), (k >= 2 && k <= 6), 1'b0});
            end
            if (k == 6) check("b2b final rdat", 128'(rsp_rdat), 128'h44444444);
            if (k < 4) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_adr   = 32'(k * 4);
                req_sel   = 4'hf;
                req_wdat  = 32'h11111111 * 32'(k + 1);
            end else if (k == 4) begin
                req_valid = 1'b1;
                req_we    = 1'b0;
                req_adr   = 32'h20;
                req_wdat  = 32'h0;
            end else begin
                req_valid = 1'b0;
            end
        end
        ack_mode = 2'd0;

        // watchdog abort with ACK tied low
        ack_mode = 2'd2;
        @(negedge CLK_I);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h40;
        req_sel   = 4'hf;
        @(posedge CLK_I);
        #1;
        req_valid = 1'b0;
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge CLK_I);
            if (!CYC_O) break;
            cnt++;
        end
        check("timeout cyc cycles", 128'(cnt), 128'd4);
        check("timeout rsp", {STB_O, rsp_valid, rsp_err, rsp_rdat}, {1'b0, 1'b1, 1'b1, 32'h0});
        ack_mode = 2'd0;
        v = '{1'b0, 32'h44, 4'hf, 32'h0, 0, 32'h44444444, 1'b0, 1};
        do_txn(v, "after_timeout");

        // reset in the middle of a slow read
        slv_lat = 10;
        @(negedge CLK_I);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h80;
        req_sel   = 4'hf;
        @(posedge CLK_I);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge CLK_I);
        #2;
        RST_I = 1'b1;
        #1;
        check("async reset cyc/stb", {CYC_O, STB_O}, 128'd0);
        pulses = 0;
        repeat (2) begin
            @(negedge CLK_I);
            if (rsp_valid) pulses++;
        end
        RST_I = 1'b0;
        repeat (15) begin
            @(negedge CLK_I);
            if (rsp_valid || CYC_O) pulses++;
        end
        check("no rsp after reset", 128'(pulses), 128'd0);
        v = '{1'b0, 32'h84, 4'hf, 32'h0, 0, 32'h44444444, 1'b0, 1};
        do_txn(v, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_req_master
`default_nettype wire
